// File: rtl/fast_pixel_streamer_pkg.sv
// Shared defaults and state encoding for the fast pixel streamer.
// Imported by the streamer and its stream interface.
package fast_pkg;

  localparam int unsigned COL_NUM_DEF     = 640;
  localparam int unsigned ROW_NUM_DEF     = 480;
  localparam int unsigned PIXEL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/fast_pixel_streamer_if.sv
// AXI-stream style DMA pixel bus feeding fast_pixel_streamer.
// The master drives beats; the slave answers with tready.
interface fast_pixel_streamer_if
  import fast_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF
);
  logic [PIXEL_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/fast_pixel_streamer.sv
// DMA pixel stream to window-generator strobe converter with frame tracking.
// Optional post-frame zero drain enabled by macro FAST_STREAM_FLUSH_EN.
module fast_pixel_streamer
  import fast_pkg::*;
#(
  parameter int unsigned COL_NUM     = COL_NUM_DEF,
  parameter int unsigned ROW_NUM     = ROW_NUM_DEF,
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int unsigned FLUSH_LEN   = 3 * COL_NUM + 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tuser,
  input  logic                   s_tlast,
  input  logic                   abort,
  output logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_ce,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_line,
  output logic                   err_sof,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int unsigned RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int unsigned FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROW_NUM - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [FW-1:0]   flush_cnt;

  logic accept;
  logic take;
  logic at_line_end;
  logic at_frame_end;
  logic at_origin;

  assign s_tready     = (state != ST_FLUSH);
  assign busy         = (state != ST_IDLE);
  assign accept       = s_tvalid & s_tready;
  assign at_line_end  = (col == COL_LAST);
  assign at_frame_end = at_line_end && (row == ROW_LAST);
  assign at_origin    = (col == '0) && (row == '0);

  // A beat is forwarded in STREAM, or in IDLE only when it opens a frame.
  assign take = accept && ((state == ST_STREAM) || ((state == ST_IDLE) && s_tuser));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      flush_cnt  <= '0;
      pix_data   <= '0;
      pix_ce     <= 1'b0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_sof    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      pix_data   <= '0;
      pix_ce     <= 1'b0;
      frame_done <= 1'b0;

      if (abort) begin
        state     <= ST_IDLE;
        col       <= '0;
        row       <= '0;
        flush_cnt <= '0;
      end else begin
        if (take) begin
          pix_data <= s_tdata;
          pix_ce   <= 1'b1;
          if (s_tlast != at_line_end) begin
            err_line <= 1'b1;
          end
          if (s_tuser && (state == ST_STREAM) && !at_origin) begin
            err_sof <= 1'b1;
          end
          if (at_frame_end) begin
            col <= '0;
            row <= '0;
`ifdef FAST_STREAM_FLUSH_EN
            state     <= ST_FLUSH;
            flush_cnt <= '0;
`else
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
`endif
          end else begin
            state <= ST_STREAM;
            if (at_line_end) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        // Only entered when the drain is built in; otherwise this branch is dead logic.
        if (state == ST_FLUSH) begin
          pix_ce <= 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            state      <= ST_IDLE;
            flush_cnt  <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fast_pixel_streamer.sv
// Randomized scoreboard bench for fast_pixel_streamer (8x4 frame, 36-pixel drain).
module tb_fast_pixel_streamer;

  localparam int COL = 8;
  localparam int ROW = 4;
  localparam int PW  = 8;
  localparam int FL  = 36;
  localparam int N   = COL * ROW;
`ifdef FAST_STREAM_FLUSH_EN
  localparam int FLUSH_ON = 1;
`else
  localparam int FLUSH_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] pix_data;
  logic          pix_ce;
  logic          busy;
  logic          frame_done;
  logic          err_line;
  logic          err_sof;
  logic [15:0]   frame_cnt;

  fast_pixel_streamer_if #(.PIXEL_WIDTH(PW)) sif ();

  fast_pixel_streamer #(
    .COL_NUM(COL), .ROW_NUM(ROW), .PIXEL_WIDTH(PW), .FLUSH_LEN(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(sif.tdata), .s_tvalid(sif.tvalid), .s_tready(sif.tready),
    .s_tuser(sif.tuser), .s_tlast(sif.tlast), .abort(abort),
    .pix_data(pix_data), .pix_ce(pix_ce), .busy(busy), .frame_done(frame_done),
    .err_line(err_line), .err_sof(err_sof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] data;
    logic          done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: frame position is simply the beat index within the frame.
  bit in_frame = 1'b0;
  int idx = 0;
  int exp_frames = 0;
  bit exp_el = 1'b0;
  bit exp_es = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t e;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (pix_ce === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pix_ce: got data %0h, expected no pixel at %0t", pix_data, $time);
        end else begin
          e = q.pop_front();
          check("pix_data", pix_data, e.data);
          check("frame_done_with_pixel", frame_done, e.done);
        end
      end else begin
        check("frame_done_without_pixel", frame_done, 0);
      end
    end
  end

  task automatic model_accept(input logic [PW-1:0] data, input bit user, input bit last);
    if (!in_frame && user) begin
      in_frame = 1'b1;
      idx      = 0;
    end
    if (in_frame) begin
      if (last != ((idx % COL) == COL - 1)) exp_el = 1'b1;
      if (user && idx != 0) exp_es = 1'b1;
      q.push_back(exp_t'{data, (idx == N - 1) && (FLUSH_ON == 0)});
      idx++;
      if (idx == N) begin
        in_frame = 1'b0;
        exp_frames++;
        for (int k = 0; k < FL * FLUSH_ON; k++) q.push_back(exp_t'{'0, k == FL - 1});
      end
    end
  endtask

  task automatic send_beat(input logic [PW-1:0] data, input bit user, input bit last);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      sif.tvalid = 1'b0;
    end
    @(negedge clk);
    sif.tdata  = data;
    sif.tvalid = 1'b1;
    sif.tuser  = user;
    sif.tlast  = last;
    while (sif.tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("tready_timeout", sif.tready, 1);
      sif.tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(data, user, last);
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort      = 1'b1;
    sif.tvalid = 1'b1;
    sif.tdata  = PW'($urandom);
    sif.tuser  = 1'b1;
    sif.tlast  = 1'b0;
    @(posedge clk);
    in_frame = 1'b0;
    @(negedge clk);
    abort      = 1'b0;
    sif.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int tlast_idx, input int sof_idx, input int abort_idx, input int stop_idx);
    for (int i = 0; i < N; i++) begin
      if (i == stop_idx) return;
      if (i == abort_idx) begin
        do_abort();
        return;
      end
      send_beat(PW'($urandom), (i == 0) || (i == sof_idx),
                (((i % COL) == COL - 1) ? 1'b1 : 1'b0) ^ ((i == tlast_idx) ? 1'b1 : 1'b0));
    end
  endtask

  task automatic end_check();
    int n = 0;
    @(negedge clk);
    sif.tvalid = 1'b0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_pending", q.size(), 0);
    check("frame_cnt", frame_cnt, exp_frames);
    check("err_line", err_line, exp_el);
    check("err_sof", err_sof, exp_es);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_ce", pix_ce, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err_line", err_line, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_tready", sif.tready, 1);
  endtask

  initial begin
    sif.tvalid = 1'b0;
    sif.tdata  = '0;
    sif.tuser  = 1'b0;
    sif.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Clean frame
    send_frame(-1, -1, -1, -1);
    end_check();

    // Stray beats before start of frame are dropped
    for (int j = 0; j < 3; j++) send_beat(PW'($urandom), 1'b0, 1'($urandom));
    send_frame(-1, -1, -1, -1);
    end_check();

    // Early tlast at row 1, col 5
    send_frame(COL + 5, -1, -1, -1);
    end_check();

    // Misplaced tuser at beat 10
    send_frame(-1, 10, -1, -1);
    end_check();

    // Abort mid-frame, then a clean frame
    send_frame(-1, -1, 20, -1);
    send_frame(-1, -1, -1, -1);
    end_check();

    // Asynchronous reset while busy
`ifdef FAST_STREAM_FLUSH_EN
    send_frame(-1, -1, -1, -1);
    @(negedge clk);
    sif.tvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_busy", busy, 1);
    check("flush_tready", sif.tready, 0);
`else
    send_frame(-1, -1, -1, 15);
    @(negedge clk);
    sif.tvalid = 1'b0;
    check("stream_busy", busy, 1);
`endif
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    in_frame   = 1'b0;
    idx        = 0;
    exp_frames = 0;
    exp_el     = 1'b0;
    exp_es     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_tready", sif.tready, 1);
    mon_en = 1'b1;

    // Partial frame is gone; only a tuser beat starts the next frame
    for (int j = 0; j < 2; j++) send_beat(PW'($urandom), 1'b0, 1'b0);
    send_frame(-1, -1, -1, -1);
    end_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fast_pixel_streamer.md
FAST_PIXEL_STREAMER -- requirements
Module: fast_pixel_streamer

Interface
REQ-001 SHALL have parameter COL_NUM, default 640: pixels per line.
REQ-002 SHALL have parameter ROW_NUM, default 480: lines per frame.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8: pixel bits.
REQ-004 SHALL have parameter FLUSH_LEN, default 3*COL_NUM+12: drain pixels issued after each frame.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port s_tdata, input, PIXEL_WIDTH: DMA pixel.
REQ-008 SHALL have port s_tvalid, input, 1: beat valid.
REQ-009 SHALL have port s_tready, output, 1: beat accepted when s_tvalid and s_tready are both high.
REQ-010 SHALL have port s_tuser, input, 1: start of frame, first pixel.
REQ-011 SHALL have port s_tlast, input, 1: end of line, last pixel of a line.
REQ-012 SHALL have port abort, input, 1: synchronous return to IDLE.
REQ-013 SHALL have port pix_data, output, PIXEL_WIDTH: pixel to the window generator data_in.
REQ-014 SHALL have port pix_ce, output, 1: one-cycle strobe per pixel, drives the window generator ce.
REQ-015 SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse at frame completion.
REQ-017 SHALL have port err_line, output, 1: sticky tlast mismatch.
REQ-018 SHALL have port err_sof, output, 1: sticky misplaced tuser.
REQ-019 SHALL have port frame_cnt, output, 16: completed frames, wraps at 65535->0.

Function
REQ-020 SHALL implement states IDLE, STREAM, FLUSH.
REQ-021 s_tready SHALL be high in IDLE and STREAM and low in FLUSH; it SHALL be combinational from the state only.
REQ-022 In IDLE, accepted beats with s_tuser=0 SHALL be discarded, with no pix_ce.
REQ-023 In IDLE, an accepted beat with s_tuser=1 SHALL be forwarded as pixel (row 0, col 0), and the state SHALL go to STREAM.
REQ-024 Each accepted beat in STREAM SHALL be forwarded: registered pix_data=s_tdata and pix_ce=1, with exactly 1-cycle latency.
REQ-025 pix_ce SHALL be 0 in every cycle without a forwarded or flush pixel.
REQ-026 The col and row counters SHALL define line and frame position.
- col wraps at COL_NUM-1 and then increments row.
- s_tlast SHALL NOT alter the counters.
REQ-027 Beats with s_tlast != (col==COL_NUM-1) SHALL set err_line and SHALL still be forwarded.
REQ-028 A beat with s_tuser=1 at any position other than (0,0) in STREAM SHALL set err_sof and SHALL be forwarded as an ordinary pixel, with no resync.
REQ-029 The accepted beat at (ROW_NUM-1, COL_NUM-1) SHALL cause a transition to FLUSH, with the flush counter loaded to 0.
REQ-030 In FLUSH, the block SHALL emit pix_data=0 with pix_ce=1 on each of FLUSH_LEN consecutive cycles.
REQ-031 After the last flush cycle, the block SHALL pulse frame_done on the same cycle as the last flush pix_ce, increment frame_cnt, and enter IDLE.
REQ-032 abort=1 SHALL force IDLE next cycle and clear counters, with no frame_done and no flush.
- abort has priority over all transitions.
- A beat presented in the abort cycle is not forwarded.
REQ-033 err_line and err_sof SHALL clear only on reset.

Reset
REQ-034 rst_n low SHALL asynchronously force:
- state IDLE;
- col=0, row=0, flush counter=0;
- pix_data=0, pix_ce=0, frame_done=0;
- err_line=0, err_sof=0, frame_cnt=0.
REQ-035 Reset mid-frame SHALL discard the partial frame; the next frame SHALL begin only on a tuser beat.

Configuration
REQ-036 Macro FAST_STREAM_FLUSH_EN defined: the FLUSH state is present, as specified above.
REQ-037 Macro FAST_STREAM_FLUSH_EN undefined: there is no FLUSH state.
- The last pixel beat goes directly to IDLE.
- frame_done pulses with that pixel's pix_ce.
- FLUSH_LEN is ignored.

Structure
REQ-038 COL_NUM/ROW_NUM/PIXEL_WIDTH defaults and the state enum SHALL live in shared package fast_pkg.
REQ-039 The block SHALL be one module with no sub-module; counters and FSM are inline.

Verification (COL_NUM=8, ROW_NUM=4, FLUSH_LEN=36)
REQ-040 Scenario: clean frame of 32 beats with correct tuser/tlast.
- Required: 32 pix_ce carrying the data.
- Then 36 pix_ce with data 0.
- frame_done on cycle 68 of output; frame_cnt=1; no errors.
REQ-041 Scenario: 3 beats without tuser, then a clean frame -> the first 3 beats are dropped, with no pix_ce; the frame then proceeds as in REQ-040.
REQ-042 Scenario: tlast on beat col 5 of row 1 -> err_line=1, and all 32 pixels are still forwarded with unchanged counters.
REQ-043 Scenario: tuser on beat 10 -> err_sof=1, and the frame completes after beat 32.
REQ-044 Scenario: abort at beat 20, then a clean frame -> no frame_done for the aborted frame; the new frame completes normally.
REQ-045 Scenario: rst_n pulse during FLUSH -> all outputs are 0 immediately, asynchronously, and s_tready=1 after release.
